// File: rtl/top_level_pkg.sv
// Shared widths and opcode encodings for the switch/button ALU board wrapper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package top_level_pkg;

    localparam int NB_BTN = 3;
    localparam int NB_OP  = 6;
    localparam int NB_AB  = 4;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // Opcode loaded into the OP register by reset
    localparam logic [5:0] OP_RESET = OP_ADD;

endpackage

// File: rtl/top_level_alu.sv
// Combinational ALU: add/sub/logic/shift of a and b selected by op.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result always valid for the current inputs.
// Ports: a, b (NB_AB operands), op (NB_OP opcode), result (NB_AB).
module alu
    import top_level_pkg::*;
#(
    parameter int NB_OP = 6,
    parameter int NB_AB = 4
) (
    input  logic [NB_AB-1:0] a,
    input  logic [NB_AB-1:0] b,
    input  logic [NB_OP-1:0] op,
    output logic [NB_AB-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            // Shift amounts >= NB_AB are well defined in SV: >>> fills every
            // bit with the sign, >> yields zero. That is exactly the wanted
            // saturation, so no explicit range check is needed.
            OP_SRA: result = $unsigned($signed(a) >>> b);
            OP_SRL: result = a >> b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/top_level.sv
// Board wrapper: buttons capture switches into A/B/OP, LEDs show ALU(A,B,OP).
// Latency: register load on the clock edge with a button held; LEDs follow combinationally.
// Backpressure: none; a held button reloads on every edge, with no edge detection.
// Ports: clock, i_reset (async active-low), i_sw[NB_OP], i_btn[NB_BTN]
//        (bit0=A, bit1=B, bit2=OP), o_led[NB_AB] = ALU result.
module top_level
    import top_level_pkg::*;
#(
    parameter int NB_BTN = top_level_pkg::NB_BTN,
    parameter int NB_OP  = top_level_pkg::NB_OP,
    parameter int NB_AB  = top_level_pkg::NB_AB
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_OP-1:0]  i_sw,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_AB-1:0]  o_led
);

    logic [NB_AB-1:0] reg_a;
    logic [NB_AB-1:0] reg_b;
    logic [NB_OP-1:0] reg_op;

    // Each button independently gates its own register; simultaneous presses
    // load every selected register from the same switch value.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= NB_OP'(OP_RESET);
        end else begin
            if (i_btn[0]) reg_a  <= i_sw[NB_AB-1:0];
            if (i_btn[1]) reg_b  <= i_sw[NB_AB-1:0];
            if (i_btn[2]) reg_op <= i_sw;
        end
    end

    alu #(
        .NB_OP (NB_OP),
        .NB_AB (NB_AB)
    ) u_alu (
        .a      (reg_a),
        .b      (reg_b),
        .op     (reg_op),
        .result (o_led)
    );

endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: stimulus pushes expected LED values,
// a monitor process pops and compares them against o_led.
// Directed vectors plus a short random ADD regression.
module tb_top_level;

    logic       clock;
    logic       i_reset;
    logic [5:0] i_sw;
    logic [2:0] i_btn;
    logic [3:0] o_led;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];
    string      name_q[$];
    event       sample_ev;

    top_level dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .i_btn   (i_btn),
        .o_led   (o_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: on each request, wait 1 time unit then drain and compare.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                logic [3:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                tests_run++;
                if (o_led !== e) begin
                    tests_failed++;
                    $display("FAIL %s: o_led=%b expected=%b", n, o_led, e);
                end
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic expect_led(input logic [3:0] val, input string name);
        exp_q.push_back(val);
        name_q.push_back(name);
        -> sample_ev;
        #2;
    endtask

    // Present switches/buttons for exactly one rising edge, then release buttons.
    task automatic press(input logic [5:0] sw, input logic [2:0] btn);
        i_sw  = sw;
        i_btn = btn;
        @(posedge clock);
        #1;
        i_btn = 3'b000;
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        press({2'b00, a}, 3'b001);
        press({2'b00, b}, 3'b010);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rsum;

        i_reset = 1'b0;
        i_sw    = 6'b000000;
        i_btn   = 3'b000;

        // Reset held for two edges, with buttons pressed that must be ignored
        @(posedge clock);
        #1;
        i_sw  = 6'b111111;
        i_btn = 3'b111;
        @(posedge clock);
        #1;
        expect_led(4'b0000, "reset_hold");
        i_btn   = 3'b000;
        i_sw    = 6'b000000;
        i_reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        expect_led(4'b0000, "post_reset_idle");

        // ADD is the reset opcode
        press(6'b000011, 3'b001);
        expect_led(4'b0011, "load_a_only");
        press(6'b000101, 3'b010);
        expect_led(4'b1000, "add_3_5");
        load_ab(4'b1111, 4'b0010);
        expect_led(4'b0001, "add_wrap");

        // Opcode sweep, A=1001 B=0011
        load_ab(4'b1001, 4'b0011);
        expect_led(4'b1100, "add_9_3");
        press(6'b100010, 3'b100); expect_led(4'b0110, "sub");
        press(6'b100100, 3'b100); expect_led(4'b0001, "and");
        press(6'b100101, 3'b100); expect_led(4'b1011, "or");
        press(6'b100110, 3'b100); expect_led(4'b1010, "xor");
        press(6'b100111, 3'b100); expect_led(4'b0100, "nor");
        press(6'b000011, 3'b100); expect_led(4'b1111, "sra");
        press(6'b000010, 3'b100); expect_led(4'b0001, "srl");
        press(6'b111111, 3'b100); expect_led(4'b0000, "illegal_op");
        press(6'b000000, 3'b100); expect_led(4'b0000, "op_zero");

        // Shift boundaries, A=1000
        load_ab(4'b1000, 4'b0100);
        press(6'b000011, 3'b100); expect_led(4'b1111, "sra_b4");
        press(6'b000010, 3'b100); expect_led(4'b0000, "srl_b4");
        load_ab(4'b1000, 4'b1111);
        expect_led(4'b0000, "srl_b15");
        press(6'b000011, 3'b100); expect_led(4'b1111, "sra_b15");
        press(6'b000000, 3'b010); expect_led(4'b1000, "sra_b0");
        press(6'b000010, 3'b100); expect_led(4'b1000, "srl_b0");
        press(6'b000001, 3'b010); expect_led(4'b0100, "srl_b1");

        // Simultaneous buttons: A and B from the same switches, then ADD
        press(6'b100000, 3'b100);
        press(6'b000110, 3'b011);
        expect_led(4'b1100, "dual_load_add");

        // Switches moving with no button must not change the result
        for (int k = 0; k < 5; k++) begin
            i_sw = 6'(k * 13 + 7);
            @(posedge clock);
            #1;
            expect_led(4'b1100, "no_btn_hold");
        end

        // Held button reloads A on every edge; B stays 0110
        i_btn = 3'b001;
        i_sw  = 6'b000001;
        @(posedge clock);
        #1;
        expect_led(4'b0111, "held_btn_edge1");
        i_sw = 6'b000011;
        @(posedge clock);
        #1;
        expect_led(4'b1001, "held_btn_edge2");
        i_btn = 3'b000;

        // Random ADD regression
        for (int it = 0; it < 20; it++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rsum = ra + rb;
            load_ab(ra, rb);
            expect_led(rsum, "rand_add");
        end

        // Reset asserted between edges clears the result immediately
        load_ab(4'b0101, 4'b0110);
        expect_led(4'b1011, "pre_async_reset");
        #1;
        i_reset = 1'b0;
        expect_led(4'b0000, "async_reset_now");
        i_sw  = 6'b001111;
        i_btn = 3'b001;
        @(posedge clock);
        #1;
        expect_led(4'b0000, "reset_blocks_load");
        i_btn   = 3'b000;
        #2;
        i_reset = 1'b1;
        press(6'b000111, 3'b001);
        expect_led(4'b0111, "load_after_reset");

        #5;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
